// File: rtl/chip8_timers.sv
// chip8_timers: prescaled down-counting timer channels (delay/sound) with
// one-shot or auto-reload modes, registered readback and a sticky illegal-load flag.
module chip8_timers #(
    parameter int DIV        = 16,
    parameter int NUM_TIMERS = 2,
    parameter int WIDTH      = 8,
    parameter int SEL_W      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  ld,
    input  logic [SEL_W-1:0]      ld_sel,
    input  logic [WIDTH-1:0]      ld_val,
    input  logic                  ld_reload,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [WIDTH-1:0]      rd_val,
    output logic                  tick,
    output logic [NUM_TIMERS-1:0] active,
    output logic [NUM_TIMERS-1:0] expired,
    output logic                  sound,
    output logic                  err
);
    localparam int PW = $clog2(DIV);

    logic [PW-1:0]         presc_q, presc_d;
    logic [WIDTH-1:0]      cnt_q [NUM_TIMERS], cnt_d [NUM_TIMERS];
    logic [WIDTH-1:0]      rel_q [NUM_TIMERS], rel_d [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] mode_q, mode_d, exp_q, exp_d, ld_hit;
    logic [WIDTH-1:0]      rd_q, rd_d;
    logic                  tick_q, err_q, err_d, dec;

    assign dec = en && presc_q == PW'(DIV - 1);

    always_comb begin
        presc_d = en ? (dec ? '0 : presc_q + 1'b1) : presc_q;
        rd_d    = '0;
        ld_hit  = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            ld_hit[i] = ld && ld_sel == SEL_W'(i);
            // a same-edge load wins over the decrement and suppresses expiry
            cnt_d[i]  = ld_hit[i] ? ld_val
                      : (dec && cnt_q[i] != '0) ? (cnt_q[i] == WIDTH'(1) ? (mode_q[i] ? rel_q[i] : '0)
                                                                         : cnt_q[i] - 1'b1)
                      : cnt_q[i];
            rel_d[i]  = ld_hit[i] ? ld_val : rel_q[i];
            mode_d[i] = ld_hit[i] ? ld_reload : mode_q[i];
            exp_d[i]  = dec && cnt_q[i] == WIDTH'(1) && !ld_hit[i];
            active[i] = cnt_q[i] != '0;
            if (rd_sel == SEL_W'(i)) rd_d = cnt_q[i];
        end
        err_d = err_q | (ld & ~|ld_hit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            cnt_q   <= '{default: '0};
            rel_q   <= '{default: '0};
            mode_q  <= '0;
            exp_q   <= '0;
            rd_q    <= '0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            mode_q  <= mode_d;
            exp_q   <= exp_d;
            rd_q    <= rd_d;
            tick_q  <= dec;
            err_q   <= err_d;
        end
    end

    assign rd_val  = rd_q;
    assign tick    = tick_q;
    assign expired = exp_q;
    assign err     = err_q;

    if (NUM_TIMERS >= 2) begin : g_snd
        assign sound = active[1];
    end else begin : g_nosnd
        assign sound = 1'b0;
    end
endmodule

// File: tb/tb_chip8_timers.sv
// tb_chip8_timers: directed scoreboard bench for chip8_timers (DIV=4, two channels,
// SEL_W=2 so that selects 2 and 3 are illegal).
module tb_chip8_timers;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, ld = 1'b0, ld_reload = 1'b0;
    logic [1:0] ld_sel = '0, rd_sel = '0;
    logic [7:0] ld_val = '0, rd_val;
    logic       tick, sound, err;
    logic [1:0] active, expired;

    typedef struct {string tag; logic [31:0] v;} exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_err = 0;

    chip8_timers #(.DIV(4), .NUM_TIMERS(2), .WIDTH(8), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_sel(ld_sel), .ld_val(ld_val),
        .ld_reload(ld_reload), .rd_sel(rd_sel), .rd_val(rd_val), .tick(tick),
        .active(active), .expired(expired), .sound(sound), .err(err)
    );

    always #5 clk = ~clk;

    task automatic push(input string t, input logic [31:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0h expected an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [1:0] s, input logic [7:0] v, input logic r);
        ld = 1'b1; ld_sel = s; ld_val = v; ld_reload = r;
    endtask

    task automatic all_zero(input string t);
        push({t, "_tick"}, 0); push({t, "_exp"}, 0); push({t, "_act"}, 0);
        push({t, "_snd"}, 0); push({t, "_rd"}, 0); push({t, "_err"}, 0);
        pop_chk(tick); pop_chk(expired); pop_chk(active);
        pop_chk(sound); pop_chk(rd_val); pop_chk(err);
    endtask

    initial begin
        adv(2);
        all_zero("reset");
        // one-shot ch0=3; edges counted from reset release
        rst = 1'b1; en = 1'b1; rd_sel = 2'd0; load(2'd0, 8'd3, 1'b0);
        push("os_rd_s1", 0); push("os_act_s1", 2'b01);
        adv(1); ld = 1'b0; pop_chk(rd_val); pop_chk(active);
        push("os_rd_s2", 3); push("os_tick_s3", 0); push("os_tick_s4", 1); push("os_rd_s4", 3);
        adv(1); pop_chk(rd_val);
        adv(1); pop_chk(tick);
        adv(1); pop_chk(tick); pop_chk(rd_val);
        push("os_rd_s5", 2); push("os_tick_s5", 0);
        adv(1); pop_chk(rd_val); pop_chk(tick);
        push("os_tick_s8", 1); push("os_exp_s8", 0); push("os_rd_s9", 1);
        adv(3); pop_chk(tick); pop_chk(expired);
        adv(1); pop_chk(rd_val);
        push("os_tick_s12", 1); push("os_exp_s12", 2'b01); push("os_act_s12", 0);
        adv(3); pop_chk(tick); pop_chk(expired); pop_chk(active);
        push("os_exp_s13", 0); push("os_rd_s13", 0);
        adv(1); pop_chk(expired); pop_chk(rd_val);
        // auto-reload ch1=2
        load(2'd1, 8'd2, 1'b1); rd_sel = 2'd1;
        push("ar_act_s14", 2'b10); push("ar_snd_s14", 1);
        adv(1); ld = 1'b0; pop_chk(active); pop_chk(sound);
        for (int k = 15; k <= 29; k++) begin
            push($sformatf("ar_snd_s%0d", k), 1);
            push($sformatf("ar_tick_s%0d", k), (k % 4 == 0) ? 1 : 0);
            push($sformatf("ar_exp_s%0d", k), (k == 20 || k == 28) ? 2'b10 : 2'b00);
            adv(1); pop_chk(sound); pop_chk(tick); pop_chk(expired);
            if (k == 17 || k == 21 || k == 25) begin
                push($sformatf("ar_rd_s%0d", k), (k == 21) ? 2 : 1);
                pop_chk(rd_val);
            end
        end
        // ch0=5, ch1=5, then reload ch0=9 exactly on decrement edge E32
        load(2'd0, 8'd5, 1'b0); adv(1);
        load(2'd1, 8'd5, 1'b0); adv(1);
        load(2'd0, 8'd9, 1'b0);
        push("ovr_tick", 1); push("ovr_exp", 0);
        adv(1); ld = 1'b0; rd_sel = 2'd0; pop_chk(tick); pop_chk(expired);
        push("ovr_ch0", 9); adv(1); rd_sel = 2'd1; pop_chk(rd_val);
        push("ovr_ch1", 4); adv(1); pop_chk(rd_val);
        // pause 10 edges with two edges left in the interval
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push("pause_tick", 0); push("pause_rd", 4);
            adv(1); pop_chk(tick); pop_chk(rd_val);
        end
        en = 1'b1;
        push("resume_tick_s45", 0); push("resume_tick_s46", 1); push("resume_rd", 3);
        adv(1); pop_chk(tick);
        adv(1); pop_chk(tick);
        adv(1); pop_chk(rd_val);
        // illegal select
        load(2'd3, 8'd7, 1'b0); rd_sel = 2'd3;
        push("ill_err", 1); push("ill_rd", 0);
        adv(1); ld = 1'b0; rd_sel = 2'd0; pop_chk(err); pop_chk(rd_val);
        push("ill_ch0", 8); push("ill_err_sticky", 1);
        adv(1); rd_sel = 2'd1; pop_chk(rd_val); pop_chk(err);
        push("ill_ch1", 3); push("ill_err_s50", 1); push("ill_tick_s50", 1);
        adv(1); pop_chk(rd_val); pop_chk(err); pop_chk(tick);
        // asynchronous reset between edges with ch0=4
        load(2'd0, 8'd4, 1'b0); rd_sel = 2'd0;
        adv(1); ld = 1'b0;
        #2 rst = 1'b0;
        #1 all_zero("arst");
        adv(1); rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("rel_tick_%0d", k), (k == 4) ? 1 : 0);
            push($sformatf("rel_exp_%0d", k), 0);
            push($sformatf("rel_act_%0d", k), 0);
            adv(1); pop_chk(tick); pop_chk(expired); pop_chk(active);
        end
        // loading 0 stops an auto-reload channel silently
        load(2'd0, 8'd1, 1'b1);
        push("z_act_on", 2'b01); adv(1); pop_chk(active);
        load(2'd0, 8'd0, 1'b1);
        push("z_act_off", 0); adv(1); ld = 1'b0; pop_chk(active);
        push("z_tick", 1); push("z_exp", 0);
        adv(2); pop_chk(tick); pop_chk(expired);
        if (sb.size() != 0) begin
            n_err++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
